// File: rtl/tlc5941_pkg.sv
// Shared constants and word types for the TLC5941 device model and the pixel driver bench.
package tlc5941_pkg;

    localparam int CHANNELS      = 16;
    localparam int GS_BITS       = 12;
    localparam int DC_BITS       = 6;
    localparam int GS_FRAME_BITS = CHANNELS * GS_BITS;
    localparam int DC_FRAME_BITS = CHANNELS * DC_BITS;
    localparam int CNT_BITS      = 8;

    typedef logic [GS_FRAME_BITS-1:0] gs_word_t;
    typedef logic [DC_FRAME_BITS-1:0] dc_word_t;

    // Pin positions inside the synchronizer vectors
    localparam int PIN_SCLK  = 0;
    localparam int PIN_SIN   = 1;
    localparam int PIN_XLAT  = 2;
    localparam int PIN_MODE  = 3;
    localparam int PIN_BLANK = 4;
    localparam int PIN_GSCLK = 5;

    function automatic logic [GS_BITS-1:0] gs_channel(input gs_word_t word, input int n);
        return word[n*GS_BITS +: GS_BITS];
    endfunction

endpackage

// File: rtl/tlc5941_pwm.sv
// Grayscale PWM engine: one shared counter compared against each channel's latched GS value.
module tlc5941_pwm
    import tlc5941_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     blank,
    input  logic                     gsclk_edge,
    input  logic [GS_FRAME_BITS-1:0] gs_latched,
    output logic [CHANNELS-1:0]      led_out
);

    logic [GS_BITS-1:0]  gs_cnt_r;
    logic                started_r;
    logic [CHANNELS-1:0] led_next_s;
    logic [CHANNELS-1:0] led_out_r;

    // Counter and start flag; the first gsclk edge after blank only arms the cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gs_cnt_r  <= {GS_BITS{1'b0}};
            started_r <= 1'b0;
        end else if (blank) begin
            gs_cnt_r  <= {GS_BITS{1'b0}};
            started_r <= 1'b0;
        end else if (gsclk_edge) begin
            if (!started_r) begin
                started_r <= 1'b1;
            end else if (gs_cnt_r != {GS_BITS{1'b1}}) begin
                gs_cnt_r <= gs_cnt_r + {{(GS_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    // Per-channel comparators
    always_comb begin
        led_next_s = {CHANNELS{1'b0}};
        for (int n = 0; n < CHANNELS; n++) begin
            if (!blank && started_r && (gs_cnt_r < gs_channel(gs_latched, n))) begin
                led_next_s[n] = 1'b1;
            end else begin
                led_next_s[n] = 1'b0;
            end
        end
    end

    // Registered channel outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led_out_r <= {CHANNELS{1'b0}};
        end else begin
            led_out_r <= led_next_s;
        end
    end

    assign led_out = led_out_r;

endmodule

// File: rtl/tlc5941_receiver.sv
// TLC5941 receiver: oversampled serial interface, GS/DC latches, framing check and PWM outputs.
module tlc5941_receiver
    import tlc5941_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          led_sclk,
    input  logic                          led_sin,
    input  logic                          led_xlat,
    input  logic                          led_mode,
    input  logic                          led_blank,
    input  logic                          led_gsclk,
    output logic                          led_sout,
    output logic [CHANNELS-1:0]           led_out,
    output logic [CHANNELS*GS_BITS-1:0]   gs_latched,
    output logic [CHANNELS*DC_BITS-1:0]   dc_latched,
    output logic                          frame_err
);

    logic [5:0]               pins_s;
    logic [5:0]               sync1_r;
    logic [5:0]               sync2_r;
    logic [3:0]               prev_r;
    logic                     sclk_edge_s;
    logic                     xlat_edge_s;
    logic                     gsclk_edge_s;
    logic                     mode_s;
    logic                     mode_chg_s;
    logic                     blank_s;
    logic                     sin_s;

    gs_word_t                 shift_r;
    gs_word_t                 shift_next_s;
    logic [CNT_BITS-1:0]      bit_cnt_r;
    logic [CNT_BITS-1:0]      cnt_next_s;
    logic                     frame_bad_s;
    gs_word_t                 gs_r;
    dc_word_t                 dc_r;
    logic                     frame_err_r;
    logic                     sout_r;

    assign pins_s = {led_gsclk, led_blank, led_mode, led_xlat, led_sin, led_sclk};

    // Two-flop synchronizers plus previous-value flops for the edge-sensitive pins
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 6'd0;
            sync2_r <= 6'd0;
            prev_r  <= 4'd0;
        end else begin
            sync1_r <= pins_s;
            sync2_r <= sync1_r;
            prev_r  <= {sync2_r[PIN_GSCLK], sync2_r[PIN_MODE], sync2_r[PIN_XLAT], sync2_r[PIN_SCLK]};
        end
    end

    assign sclk_edge_s  = sync2_r[PIN_SCLK]  & ~prev_r[0];
    assign xlat_edge_s  = sync2_r[PIN_XLAT]  & ~prev_r[1];
    assign mode_chg_s   = sync2_r[PIN_MODE]  ^  prev_r[2];
    assign gsclk_edge_s = sync2_r[PIN_GSCLK] & ~prev_r[3];
    assign mode_s       = sync2_r[PIN_MODE];
    assign blank_s      = sync2_r[PIN_BLANK];
    assign sin_s        = sync2_r[PIN_SIN];

    // Shift and count first so a coincident xlat sees the new bit and the post-increment count
    always_comb begin
        shift_next_s = shift_r;
        cnt_next_s   = bit_cnt_r;
        if (sclk_edge_s) begin
            shift_next_s = {shift_r[GS_FRAME_BITS-2:0], sin_s};
            if (bit_cnt_r != {CNT_BITS{1'b1}}) begin
                cnt_next_s = bit_cnt_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
            end else begin
                cnt_next_s = bit_cnt_r;
            end
        end else begin
            shift_next_s = shift_r;
        end
        if (mode_s) begin
            frame_bad_s = (cnt_next_s != CNT_BITS'(DC_FRAME_BITS));
        end else begin
            frame_bad_s = (cnt_next_s != CNT_BITS'(GS_FRAME_BITS));
        end
    end

    // Shift register, bit counter, latches and sticky framing flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_r     <= {GS_FRAME_BITS{1'b0}};
            bit_cnt_r   <= {CNT_BITS{1'b0}};
            gs_r        <= {GS_FRAME_BITS{1'b0}};
            dc_r        <= {DC_FRAME_BITS{1'b0}};
            frame_err_r <= 1'b0;
            sout_r      <= 1'b0;
        end else begin
            shift_r <= shift_next_s;
            sout_r  <= mode_s ? shift_next_s[DC_FRAME_BITS-1] : shift_next_s[GS_FRAME_BITS-1];
            if (xlat_edge_s || mode_chg_s) begin
                bit_cnt_r <= {CNT_BITS{1'b0}};
            end else begin
                bit_cnt_r <= cnt_next_s;
            end
            if (xlat_edge_s) begin
                if (mode_s) begin
                    dc_r <= shift_next_s[DC_FRAME_BITS-1:0];
                end else begin
                    gs_r <= shift_next_s;
                end
                if (frame_bad_s) begin
                    frame_err_r <= 1'b1;
                end
            end
        end
    end

    tlc5941_pwm u_pwm (
        .clock      (clock),
        .reset_n    (reset_n),
        .blank      (blank_s),
        .gsclk_edge (gsclk_edge_s),
        .gs_latched (gs_r),
        .led_out    (led_out)
    );

    assign led_sout   = sout_r;
    assign gs_latched = gs_r;
    assign dc_latched = dc_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_tlc5941_receiver.sv
// Self-checking bench for tlc5941_receiver: frame table, PWM model and reset/blank corner sequences.
module tb_tlc5941_receiver;
    import tlc5941_pkg::*;

    logic                        clock = 1'b0;
    logic                        reset_n = 1'b0;
    logic                        led_sclk = 1'b0;
    logic                        led_sin = 1'b0;
    logic                        led_xlat = 1'b0;
    logic                        led_mode = 1'b0;
    logic                        led_blank = 1'b1;
    logic                        led_gsclk = 1'b0;
    logic                        led_sout;
    logic [CHANNELS-1:0]         led_out;
    logic [CHANNELS*GS_BITS-1:0] gs_latched;
    logic [CHANNELS*DC_BITS-1:0] dc_latched;
    logic                        frame_err;

    int errors = 0;
    int checks = 0;
    bit bits_q[$];
    int gs_edges;

    typedef struct {
        bit mode;
        int nbits;
        bit simul;
        bit exp_err;
    } vec_t;

    vec_t vecs[9];

    tlc5941_receiver dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .led_sclk   (led_sclk),
        .led_sin    (led_sin),
        .led_xlat   (led_xlat),
        .led_mode   (led_mode),
        .led_blank  (led_blank),
        .led_gsclk  (led_gsclk),
        .led_sout   (led_sout),
        .led_out    (led_out),
        .gs_latched (gs_latched),
        .dc_latched (dc_latched),
        .frame_err  (frame_err)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bit i of the device's shift window: the i-th most recent bit shifted in since reset
    function automatic logic [191:0] window();
        logic [191:0] w;
        w = '0;
        for (int i = 0; i < 192; i++)
            if (i < bits_q.size()) w[i] = bits_q[bits_q.size()-1-i];
        return w;
    endfunction

    // A channel is on after k gsclk edges when k >= 1 and k-1 < its GS value
    function automatic logic [15:0] pwm_model(input int k, input logic [191:0] gs);
        logic [15:0] v;
        int val;
        v = '0;
        for (int n = 0; n < 16; n++) begin
            val = int'(gs[n*12 +: 12]);
            v[n] = (k >= 1) && ((k - 1) < val);
        end
        return v;
    endfunction

    function automatic logic [191:0] rand_word();
        logic [191:0] w;
        for (int i = 0; i < 6; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        bits_q.delete();
        cyc(6);
    endtask

    task automatic send_bit(input bit b, input bit with_xlat);
        led_sin = b;
        cyc(2);
        led_sclk = 1'b1;
        if (with_xlat) led_xlat = 1'b1;
        cyc(2);
        led_sclk = 1'b0;
        led_xlat = 1'b0;
        cyc(1);
        bits_q.push_back(b);
    endtask

    task automatic pulse_xlat();
        led_xlat = 1'b1;
        cyc(2);
        led_xlat = 1'b0;
        cyc(4);
    endtask

    // Send the low n bits of w MSB first (wrapping past 192), then latch
    task automatic send_word(input logic [191:0] w, input int n, input bit simul, input bit do_latch);
        for (int i = n - 1; i >= 0; i--)
            send_bit(w[i % 192], simul && do_latch && (i == 0));
        if (do_latch && !simul) pulse_xlat();
        else cyc(4);
    endtask

    task automatic gs_pulse();
        led_gsclk = 1'b1;
        cyc(3);
        led_gsclk = 1'b0;
        cyc(3);
        gs_edges++;
    endtask

    initial begin
        logic [191:0] w;
        logic [191:0] exp_w;
        int on_cnt;

        vecs[0] = '{1'b0, 192, 1'b0, 1'b0};
        vecs[1] = '{1'b1,  96, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 191, 1'b0, 1'b1};
        vecs[3] = '{1'b1,  97, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 192, 1'b1, 1'b0};
        vecs[5] = '{1'b1,  96, 1'b1, 1'b0};
        vecs[6] = '{1'b0,  96, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 192, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 193, 1'b0, 1'b1};

        cyc(3);
        chk("reset_gs", gs_latched, '0);
        chk("reset_dc", dc_latched, '0);
        chk("reset_err", frame_err, '0);
        chk("reset_led", led_out, '0);
        chk("reset_sout", led_sout, '0);
        reset_n = 1'b1;
        cyc(4);

        // Table-driven frames with random payloads
        for (int v = 0; v < 9; v++) begin
            led_mode = vecs[v].mode;
            do_reset();
            w = rand_word();
            send_word(w, vecs[v].nbits, vecs[v].simul, 1'b1);
            exp_w = window();
            if (vecs[v].mode) begin
                chk($sformatf("vec%0d_dc", v), dc_latched, exp_w[95:0]);
                chk($sformatf("vec%0d_gs_untouched", v), gs_latched, '0);
                chk($sformatf("vec%0d_sout", v), led_sout, exp_w[95]);
            end else begin
                chk($sformatf("vec%0d_gs", v), gs_latched, exp_w);
                chk($sformatf("vec%0d_dc_untouched", v), dc_latched, '0);
                chk($sformatf("vec%0d_sout", v), led_sout, exp_w[191]);
            end
            chk($sformatf("vec%0d_err", v), frame_err, vecs[v].exp_err);
        end

        // DC pattern frame
        led_mode = 1'b1;
        do_reset();
        w = '0;
        w[95:0] = {16{6'b010000}};
        send_word(w, 96, 1'b0, 1'b1);
        chk("dc_pattern", dc_latched, {16{6'b010000}});
        chk("dc_pattern_err", frame_err, 1'b0);

        // GS frame, channel 0 = 15, then 20 gsclk periods
        led_mode = 1'b0;
        do_reset();
        w = 192'h00F;
        send_word(w, 192, 1'b0, 1'b1);
        chk("gs_ch0", gs_latched, 192'h00F);
        led_blank = 1'b0;
        cyc(4);
        gs_edges = 0;
        chk("pwm_idle", led_out, pwm_model(0, w));
        on_cnt = 0;
        for (int e = 0; e < 20; e++) begin
            gs_pulse();
            chk($sformatf("pwm_ch0_e%0d", gs_edges), led_out, pwm_model(gs_edges, w));
            if (led_out[0]) on_cnt++;
        end
        chk("pwm_ch0_on_periods", on_cnt, 15);
        led_blank = 1'b1;
        cyc(4);

        // Short frame: sticky error survives a good frame, cleared by reset
        do_reset();
        send_word(rand_word(), 191, 1'b0, 1'b1);
        chk("short_gs", gs_latched, window());
        chk("short_err", frame_err, 1'b1);
        send_word(rand_word(), 192, 1'b0, 1'b1);
        chk("short_err_sticky", frame_err, 1'b1);
        do_reset();
        chk("short_err_reset", frame_err, 1'b0);

        // Blank mid-cycle: ch3 = FFF, random small values elsewhere
        w = '0;
        for (int n = 0; n < 16; n++) w[n*12 +: 12] = 12'($urandom_range(0, 120));
        w[3*12 +: 12] = 12'hFFF;
        send_word(w, 192, 1'b0, 1'b1);
        chk("blank_gs", gs_latched, w);
        led_blank = 1'b0;
        cyc(4);
        gs_edges = 0;
        for (int e = 0; e < 100; e++) begin
            gs_pulse();
            if ((e % 10) == 0 || e == 99)
                chk($sformatf("blank_run_e%0d", gs_edges), led_out, pwm_model(gs_edges, w));
        end
        led_blank = 1'b1;
        led_gsclk = 1'b1;
        cyc(4);
        chk("blank_off", led_out, '0);
        led_gsclk = 1'b0;
        cyc(3);
        gs_pulse();
        chk("blank_hold", led_out, '0);
        led_blank = 1'b0;
        cyc(4);
        gs_edges = 0;
        chk("blank_restart_idle", led_out, '0);
        for (int e = 0; e < 8; e++) begin
            gs_pulse();
            chk($sformatf("blank_restart_e%0d", gs_edges), led_out, pwm_model(gs_edges, w));
        end
        led_blank = 1'b1;
        cyc(4);

        // Reset mid-frame discards the partial frame
        do_reset();
        send_word(rand_word(), 50, 1'b0, 1'b0);
        do_reset();
        chk("midreset_gs", gs_latched, '0);
        chk("midreset_dc", dc_latched, '0);
        chk("midreset_err", frame_err, 1'b0);
        chk("midreset_led", led_out, '0);
        chk("midreset_sout", led_sout, 1'b0);
        w = rand_word();
        send_word(w, 192, 1'b0, 1'b1);
        chk("midreset_frame", gs_latched, w);
        chk("midreset_frame_err", frame_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlc5941_receiver.md
# tlc5941_receiver

Synthesizable model of one TLC5941 16-channel LED driver, the receiving end of the pixel driver's serial interface (SCLK/SIN/XLAT/MODE/BLANK/GSCLK). Oversamples the interface pins in the system clock domain, shifts and latches grayscale (GS) and dot-correction (DC) data, and regenerates the 16 PWM channel outputs. Used in loopback self-check and as the device model in pixel driver verification. Flags framing errors instead of silently accepting them.

## Interface
- CHANNELS, 16: output channels per device
- GS_BITS, 12: grayscale bits per channel (GS frame = 192 bits)
- DC_BITS, 6: dot-correction bits per channel (DC frame = 96 bits)
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- led_sclk  in  1  serial shift clock, at most clock/4
- led_sin  in  1  serial data
- led_xlat  in  1  latch strobe
- led_mode  in  1  1 = DC frame, 0 = GS frame
- led_blank  in  1  1 = outputs off, GS counter cleared
- led_gsclk  in  1  grayscale PWM clock, at most clock/4
- led_sout  out  1  serial out, MSB of the active shift window
- led_out  out  CHANNELS  PWM outputs, 1 = channel on
- gs_latched  out  CHANNELS*GS_BITS  latched GS word; channel n at [12n+11:12n]
- dc_latched  out  CHANNELS*DC_BITS  latched DC word; channel n at [6n+5:6n]
- frame_err  out  1  sticky: XLAT with wrong bit count for current mode

## Operation
- All six inputs pass through a 2-flop synchronizer, then a 1-flop edge detector; "edge" = synchronized rising edge, a 1-cycle pulse.
- Shift register: 192 bits. On sclk edge: shift left by one, sin into bit 0. led_sout = bit 191 in GS mode, bit 95 in DC mode.
- Bit counter, 8 bits, saturating at 255: +1 per sclk edge; cleared on xlat edge and on any change of synchronized mode.
- On xlat edge: mode 0 -> gs_latched <= shift[191:0]; mode 1 -> dc_latched <= shift[95:0]. If bit count != 192 (GS) / 96 (DC), frame_err <= 1; data latched regardless.
- frame_err cleared only by reset.
- PWM: 12-bit gs_cnt. While synchronized blank = 1: gs_cnt <= 0, led_out = 0. While blank = 0: gs_cnt +1 per gsclk edge, saturating at 4095. led_out[n] = !blank && (gs_cnt < gs[n]) && started, where started is set by the first gsclk edge after blank falls and cleared by blank.
- GS value 0 -> channel never on; 4095 -> on for 4095 gsclk periods, then off.
- DC value has no effect on led_out; it is exposed for checking only.

## Timing
- Reset: shift register, bit counter, gs_latched, dc_latched, gs_cnt, started, frame_err, led_out, led_sout all 0; synchronizer flops 0.
- Pin edge to internal action: 3 clocks (2 sync + edge detect); led_out/gs_latched update 1 clock after that.
- sclk and xlat edges in the same cycle: shift first, latch includes the new bit, counter check uses post-increment count, then counter clears.
- Mode change and xlat in the same cycle: latch uses the new mode; counter clears.
- gsclk edge in the same cycle as blank rising: blank wins, gs_cnt <= 0.
- Reset asserted mid-frame: all state cleared immediately; partial frame discarded, no frame_err.
- Pins toggling faster than clock/4 are out of spec; behaviour undefined, no checker required.

## Structure
- Package tlc5941_pkg: CHANNELS, GS_BITS, DC_BITS, GS_FRAME_BITS = 192, DC_FRAME_BITS = 96, typedefs for gs_word_t and dc_word_t; shared with the pixel driver bench.
- Sub-module tlc5941_pwm: gs_cnt, started flag, 16 comparators; inputs blank, gsclk edge pulse, gs_latched; output led_out.
- Top holds synchronizers, edge detectors, shift register, bit counter, latches, frame check. Target 150-250 lines total.

## Test plan
- DC frame: mode=1, 96 bits of pattern 010000 repeated, xlat -> dc_latched = 16 copies of 6'b010000 (bit order per shift rule), frame_err = 0.
- GS frame: mode=0, 192 bits setting channel 0 = 12'h00F, others 0, xlat; blank falls, 20 gsclk edges -> led_out[0] high for exactly 15 gsclk periods, other channels never high.
- Short frame: mode=0, 191 sclk edges, xlat -> gs_latched updated, frame_err = 1, stays 1 until reset.
- Blank mid-cycle: GS ch3 = 12'hFFF, blank asserted after 100 gsclk edges -> led_out = 0 within 4 clocks, gs_cnt = 0; blank falls, count restarts from 0.
- Simultaneous sclk+xlat on bit 192 -> latched word includes final bit, frame_err = 0.
- Reset asserted after 50 sclk bits -> all outputs 0; subsequent full 192-bit frame latches correctly with frame_err = 0.
